// File: rtl/dc_video_tx_if.sv
// Pixel request stream between an upstream pixel source and dc_video_tx.
//   pixel_rgb   : {R,G,B} offered by the source
//   pixel_valid : pixel_rgb holds a real pixel
//   pixel_ready : transmitter samples pixel_rgb this cycle
//   pixel_x/y   : visible coordinates of the pixel being requested
// master = pixel source, slave = transmitter.
interface dc_video_tx_if;
  logic [23:0] pixel_rgb;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [11:0] pixel_x;
  logic [11:0] pixel_y;

  modport master (output pixel_rgb, pixel_valid, input pixel_ready, pixel_x, pixel_y);
  modport slave  (input pixel_rgb, pixel_valid, output pixel_ready, pixel_x, pixel_y);
endinterface

// File: rtl/dc_video_tx.sv
// dc_video_tx: Dreamcast 12-bit multiplexed digital video bus transmitter.
// Generates _hsync/_vsync and a two-clock-per-pixel indata stream
// ({R,G[7:4]} then {G[3:0],B}) with the raw 1716/1728-clock line geometry,
// pulling pixels from upstream one request per visible pixel.
// Ports:
//   clock, reset_n    : 54 MHz bus clock, async active-low reset
//   enable            : bus active; low gives the idle "no signal" bus
//   mode              : 0/3 = 525-line, 1 = 263-line 240p, 2 = 625-line PAL
//   test_pattern      : select internal colour bars (optional feature)
//   clear_status      : clears the sticky underflow flag
//   pix               : pixel request stream (dc_video_tx_if.slave)
//   _hsync, _vsync    : active-low syncs
//   indata            : multiplexed pixel word
//   frame_start       : pulse on hcnt 0 of line 0
//   underflow         : sticky, a requested pixel was not valid
// Optional feature macro: DC_TX_TEST_PATTERN_EN (internal 8-bar generator).
// All outputs are registered: every cycle the next bus position (nh, nl) is
// computed and the outputs for that position are loaded together with it.
module dc_video_tx #(
  parameter int HSYNC_LEN   = 64,
  parameter int VSYNC_LINES = 6,
  parameter int HSTART      = 260,
  parameter int VSTART      = 36,
  parameter int WIDTH       = 640,
  parameter int HEIGHT_480  = 480,
  parameter int HEIGHT_240  = 240,
  parameter int HEIGHT_PAL  = 576
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic          test_pattern,
  input  logic          clear_status,
  dc_video_tx_if.slave  pix,
  output logic          _hsync,
  output logic          _vsync,
  output logic [11:0]   indata,
  output logic          frame_start,
  output logic          underflow
);
  localparam logic [11:0] H_REQ_LO = 12'(HSTART - 1);
  localparam logic [11:0] H_REQ_HI = 12'(HSTART + 2*WIDTH - 3);
  localparam logic [11:0] H_VIS_LO = 12'(HSTART);
  localparam logic [11:0] H_VIS_HI = 12'(HSTART + 2*WIDTH - 1);
  localparam logic [11:0] V_LO     = 12'(VSTART);
  localparam logic [11:0] HS_N     = 12'(HSYNC_LEN);
  localparam logic [11:0] VS_N     = 12'(VSYNC_LINES);
  localparam int          BAR_W    = WIDTH / 8;

  logic        active_q, active_d;
  logic [11:0] hcnt_q, hcnt_d, line_q, line_d;
  logic [1:0]  mode_q, mode_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic [11:0] indata_q, indata_d, lo_q, lo_d;
  logic        ready_q, ready_d, tp_q, tp_d;
  logic [11:0] px_q, px_d, py_q, py_d;
  logic        fs_q, fs_d, uf_q, uf_d;

  logic [1:0]  mode_in, mode_n;
  logic [11:0] h_max, l_max, nh, nl, height;
  logic        frame0, vis_line, vis_pix, req, tp_en;
  logic [23:0] cap;

`ifdef DC_TX_TEST_PATTERN_EN
  assign tp_en = test_pattern;
`else
  logic unused_tp;
  assign unused_tp = test_pattern;
  assign tp_en     = 1'b0;
`endif

  // red, green, blue, white, black, cyan, yellow, magenta
  function automatic logic [23:0] bar_rgb(input logic [11:0] x);
    logic [2:0] b;
    b = '0;
    for (int i = 1; i < 8; i++)
      if (x >= 12'(i * BAR_W)) b = 3'(i);
    case (b)
      3'd0:    bar_rgb = 24'hFF0000;
      3'd1:    bar_rgb = 24'h00FF00;
      3'd2:    bar_rgb = 24'h0000FF;
      3'd3:    bar_rgb = 24'hFFFFFF;
      3'd4:    bar_rgb = 24'h000000;
      3'd5:    bar_rgb = 24'h00FFFF;
      3'd6:    bar_rgb = 24'hFFFF00;
      default: bar_rgb = 24'hFF00FF;
    endcase
  endfunction

  always_comb begin
    mode_in = (mode == 2'd3) ? 2'd0 : mode;
    h_max   = (mode_q == 2'd2) ? 12'd1727 : 12'd1715;
    case (mode_q)
      2'd1:    l_max = 12'd262;
      2'd2:    l_max = 12'd624;
      default: l_max = 12'd524;
    endcase
    // A fresh start (after reset or enable rise) always begins at (0,0).
    if (!active_q) begin
      nh = '0;
      nl = '0;
    end else if (hcnt_q == h_max) begin
      nh = '0;
      nl = (line_q == l_max) ? 12'd0 : line_q + 12'd1;
    end else begin
      nh = hcnt_q + 12'd1;
      nl = line_q;
    end
    frame0 = (nh == 12'd0) && (nl == 12'd0);
    // Mode only changes on a frame boundary so a frame never mixes geometry.
    mode_n = frame0 ? mode_in : mode_q;
    case (mode_n)
      2'd1:    height = 12'(HEIGHT_240);
      2'd2:    height = 12'(HEIGHT_PAL);
      default: height = 12'(HEIGHT_480);
    endcase
    vis_line = (nl >= V_LO) && (nl < V_LO + height);
    vis_pix  = vis_line && (nh >= H_VIS_LO) && (nh <= H_VIS_HI);
    // Request one clock ahead of each pixel's first phase (HSTART is even).
    req      = vis_line && (nh >= H_REQ_LO) && (nh <= H_REQ_HI) && nh[0];

    if (ready_q)   cap = pix.pixel_valid ? pix.pixel_rgb : 24'h0;
    else if (tp_q) cap = bar_rgb(px_q);
    else           cap = 24'h0;

    active_d = active_q;
    hcnt_d   = hcnt_q;
    line_d   = line_q;
    mode_d   = mode_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    indata_d = indata_q;
    lo_d     = lo_q;
    ready_d  = 1'b0;
    tp_d     = 1'b0;
    px_d     = px_q;
    py_d     = py_q;
    fs_d     = 1'b0;
    // Set wins over a simultaneous clear.
    uf_d     = (ready_q & ~pix.pixel_valid) | (uf_q & ~clear_status);

    if (!enable) begin
      active_d = 1'b0;
      hcnt_d   = '0;
      line_d   = '0;
      hsync_d  = 1'b1;
      vsync_d  = 1'b1;
      indata_d = 12'hFFF;
    end else begin
      active_d = 1'b1;
      hcnt_d   = nh;
      line_d   = nl;
      mode_d   = mode_n;
      hsync_d  = (nh >= HS_N);
      vsync_d  = (nl >= VS_N);
      fs_d     = frame0;
      ready_d  = req & ~tp_en;
      tp_d     = req & tp_en;
      if (req) begin
        px_d = (nh - H_REQ_LO) >> 1;
        py_d = nl - V_LO;
      end
      indata_d = 12'h000;
      if (vis_pix) begin
        if (!nh[0]) begin
          indata_d = cap[23:12];
          lo_d     = cap[11:0];
        end else begin
          indata_d = lo_q;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      hcnt_q   <= '0;
      line_q   <= '0;
      mode_q   <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      indata_q <= 12'hFFF;
      lo_q     <= '0;
      ready_q  <= 1'b0;
      tp_q     <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      fs_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      hcnt_q   <= hcnt_d;
      line_q   <= line_d;
      mode_q   <= mode_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      indata_q <= indata_d;
      lo_q     <= lo_d;
      ready_q  <= ready_d;
      tp_q     <= tp_d;
      px_q     <= px_d;
      py_q     <= py_d;
      fs_q     <= fs_d;
      uf_q     <= uf_d;
    end
  end

  assign _hsync          = hsync_q;
  assign _vsync          = vsync_q;
  assign indata          = indata_q;
  assign frame_start     = fs_q;
  assign underflow       = uf_q;
  assign pix.pixel_ready = ready_q;
  assign pix.pixel_x     = px_q;
  assign pix.pixel_y     = py_q;
endmodule

// File: tb/tb_dc_video_tx.sv
// Self-checking bench for dc_video_tx. A position-level model (line/hcnt
// arithmetic plus a queue of expected pixels) predicts every output each
// cycle; a handful of literal checks pin the model to known values.
// Geometry is shrunk (few visible lines/pixels, early VSTART) so several
// restarts and mode changes fit in a short run; raw line lengths are real.
module tb_dc_video_tx;
  localparam int HSL = 64, VSL = 2, HST = 260, VST = 2, W = 64;
  localparam int H480 = 4, H240 = 2, HPAL = 3;

  logic        clk, reset_n, enable, test_pattern, clear_status, pixel_valid;
  logic [1:0]  mode;
  logic [23:0] pixel_rgb;
  logic        hs_n, vs_n, fs, uf;
  logic [11:0] indata;

  dc_video_tx_if pif();
  assign pif.pixel_rgb   = pixel_rgb;
  assign pif.pixel_valid = pixel_valid;

  dc_video_tx #(.HSYNC_LEN(HSL), .VSYNC_LINES(VSL), .HSTART(HST), .VSTART(VST),
                .WIDTH(W), .HEIGHT_480(H480), .HEIGHT_240(H240), .HEIGHT_PAL(HPAL)) dut (
    .clock(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .test_pattern(test_pattern), .clear_status(clear_status), .pix(pif),
    ._hsync(hs_n), ._vsync(vs_n), .indata(indata), .frame_start(fs), .underflow(uf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0, n_err = 0, seg = 0;
  int cyc = 0, last_fall = -1, last_period = 0;
  logic prev_hs = 1'b1;

  // model state: position of the current cycle and expected outputs
  bit          m_active = 0;
  int          m_h = 0, m_l = 0, m_mode = 0;
  logic        e_hs = 1, e_vs = 1, e_ready = 0, e_tp = 0, e_fs = 0, e_uf = 0;
  logic [11:0] e_ind = 12'hFFF;
  int          e_x = 0, e_y = 0;
  logic [23:0] mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (line %0d hcnt %0d)", nm, act, exp, m_l, m_h);
    end
  endtask

  function automatic logic [23:0] bar(input int x);
    case (x * 8 / W)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      2: return 24'h0000FF;
      3: return 24'hFFFFFF;
      4: return 24'h000000;
      5: return 24'h00FFFF;
      6: return 24'hFFFF00;
      default: return 24'hFF00FF;
    endcase
  endfunction

  task automatic set_idle();
    e_hs = 1; e_vs = 1; e_ind = 12'hFFF; e_ready = 0; e_tp = 0; e_fs = 0;
    m_active = 0; m_h = 0; m_l = 0;
    mq.delete();
  endtask

  task automatic model_step();
    logic [23:0] c;
    int ht, lt, hgt;
    bit visl, tp_on;
    if (!reset_n) begin
      set_idle();
      m_mode = 0; e_x = 0; e_y = 0; e_uf = 0;
      return;
    end
    e_uf = (e_ready && !pixel_valid) || (e_uf && !clear_status);
    if (e_ready)   mq.push_back(pixel_valid ? pixel_rgb : 24'h0);
    else if (e_tp) mq.push_back(bar(e_x));
    e_ready = 0; e_tp = 0;
    if (!enable) begin
      set_idle();
      return;
    end
    if (!m_active) begin
      m_h = 0; m_l = 0;
    end else begin
      ht = (m_mode == 2) ? 1728 : 1716;
      lt = (m_mode == 1) ? 263 : (m_mode == 2) ? 625 : 525;
      m_h++;
      if (m_h == ht) begin
        m_h = 0;
        m_l++;
        if (m_l == lt) m_l = 0;
      end
    end
    m_active = 1;
    if (m_h == 0 && m_l == 0) m_mode = (mode == 2'd3) ? 0 : int'(mode);
    hgt  = (m_mode == 1) ? H240 : (m_mode == 2) ? HPAL : H480;
    e_hs = (m_h >= HSL);
    e_vs = (m_l >= VSL);
    e_fs = (m_h == 0 && m_l == 0);
    visl = (m_l >= VST) && (m_l < VST + hgt);
    tp_on = 0;
`ifdef DC_TX_TEST_PATTERN_EN
    tp_on = test_pattern;
`endif
    if (visl && m_h >= HST - 1 && m_h <= HST + 2*W - 3 && (m_h - (HST - 1)) % 2 == 0) begin
      if (tp_on) e_tp = 1;
      else       e_ready = 1;
      e_x = (m_h - (HST - 1)) / 2;
      e_y = m_l - VST;
    end
    e_ind = 12'h000;
    if (visl && m_h >= HST && m_h < HST + 2*W) begin
      if (mq.size() == 0) begin
        n_err++;
        $display("FAIL model_queue: no pixel for line %0d hcnt %0d", m_l, m_h);
      end else if ((m_h - HST) % 2 == 0) begin
        c = mq[0];
        e_ind = c[23:12];
      end else begin
        c = mq.pop_front();
        e_ind = c[11:0];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // cycle-by-cycle compare against the model, plus hsync period measurement
  initial forever begin
    @(negedge clk);
    cyc++;
    n_cmp++;
    if ({hs_n, vs_n, indata, pif.pixel_ready, fs, uf} !== {e_hs, e_vs, e_ind, e_ready, e_fs, e_uf}) begin
      n_err++;
      $display("FAIL outputs line %0d hcnt %0d: got hs=%b vs=%b ind=%h rdy=%b fs=%b uf=%b, expected hs=%b vs=%b ind=%h rdy=%b fs=%b uf=%b",
               m_l, m_h, hs_n, vs_n, indata, pif.pixel_ready, fs, uf, e_hs, e_vs, e_ind, e_ready, e_fs, e_uf);
    end
    if (e_ready) begin
      n_cmp++;
      if (pif.pixel_x !== 12'(e_x) || pif.pixel_y !== 12'(e_y)) begin
        n_err++;
        $display("FAIL pixel_xy: got %0d,%0d expected %0d,%0d", pif.pixel_x, pif.pixel_y, e_x, e_y);
      end
    end
    if (!m_active) last_fall = -1;
    else if (prev_hs && !hs_n) begin
      if (last_fall >= 0) last_period = cyc - last_fall;
      last_fall = cyc;
    end
    prev_hs = hs_n;
  end

  task automatic drive();
    pixel_rgb    = 24'($urandom);
    pixel_valid  = ($urandom_range(0, 15) != 0);
    clear_status = ($urandom_range(0, 99) == 0);
    test_pattern = 1'b0;
    if (seg == 1 && m_l <= 4) begin pixel_valid = 1; clear_status = 0; end
    if (seg == 1 && m_l == 2) pixel_rgb = 24'hA5C33C;
    if (seg == 1 && m_l == 3 && m_h == HST - 1 + 10) begin pixel_valid = 0; clear_status = 1; end
    if (seg == 1 && m_l == 4 && m_h == 100) clear_status = 1;
    if (seg == 1 && m_l == 4 && m_h == 500) mode = 2'd2;
    if (seg == 4 && (m_l == 2 || m_l == 3)) test_pattern = 1'b1;
  endtask

  // hand-computed expectations for the current cycle
  task automatic lit();
    if (m_active && m_h == 0 && m_l == 0) chk("frame_start_at_0_0", fs, 1);
    if (seg == 1) begin
      if (m_l == 0 && m_h == 63)  chk("hsync_low_last", hs_n, 0);
      if (m_l == 0 && m_h == 64)  chk("hsync_rise", hs_n, 1);
      if (m_l == 1 && m_h == 5)   chk("vsync_low", vs_n, 0);
      if (m_l == 2 && m_h == 0)   chk("vsync_rise", vs_n, 1);
      if (m_l == 2 && m_h == 259) begin
        chk("ready_px0", pif.pixel_ready, 1);
        chk("px0_x", pif.pixel_x, 0);
        chk("px0_y", pif.pixel_y, 0);
      end
      if (m_l == 2 && m_h == 260) chk("px0_phase0", indata, 12'hA5C);
      if (m_l == 2 && m_h == 261) chk("px0_phase1", indata, 12'h33C);
      if (m_l == 3 && m_h == 269) chk("underflow_before", uf, 0);
      if (m_l == 3 && m_h == 270) begin
        chk("drop_phase0", indata, 12'h000);
        chk("underflow_set_wins", uf, 1);
      end
      if (m_l == 3 && m_h == 271) chk("drop_phase1", indata, 12'h000);
      if (m_l == 4 && m_h == 99)  chk("underflow_sticky", uf, 1);
      if (m_l == 4 && m_h == 101) chk("underflow_cleared", uf, 0);
    end
`ifdef DC_TX_TEST_PATTERN_EN
    if (seg == 4 && m_l == 2) begin
      if (m_h == 259)             chk("tp_no_ready", pif.pixel_ready, 0);
      if (m_h == 260)             chk("tp_red_hi", indata, 12'hFF0);
      if (m_h == 261)             chk("tp_red_lo", indata, 12'h000);
      if (m_h == HST + 2*(W/8))   chk("tp_green_hi", indata, 12'h00F);
      if (m_h == HST + 2*(W/8)+1) chk("tp_green_lo", indata, 12'hF00);
    end
`endif
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    lit();
    drive();
  endtask

  task automatic run_until(input int l, input int h, input int budget);
    bit done;
    done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      step();
      if (m_active && m_l == l && m_h == h) done = 1;
    end
    chk("reached_position", 32'(m_l * 4096 + m_h), 32'(l * 4096 + h));
  endtask

  task automatic restart(input logic [1:0] md);
    mode = md;
    enable = 0;
    repeat (5) step();
    enable = 1;
  endtask

  initial begin
    reset_n = 0; enable = 0; mode = 2'd0; test_pattern = 0;
    clear_status = 0; pixel_rgb = '0; pixel_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_indata", indata, 12'hFFF);
    chk("rst_hsync", hs_n, 1);
    chk("rst_vsync", vs_n, 1);
    chk("rst_ready", pif.pixel_ready, 0);
    chk("rst_x", pif.pixel_x, 0);
    chk("rst_y", pif.pixel_y, 0);
    chk("rst_fs", fs, 0);
    chk("rst_uf", uf, 0);

    // mode 0 from reset; mode 2 requested mid-frame must not take effect yet
    reset_n = 1; enable = 1; seg = 1;
    run_until(7, 700, 20000);
    chk("period_mode0_after_midframe_switch", last_period, 1716);

    // enable low mid-line, then re-enable: mode 2 latches at the restart
    seg = 2;
    enable = 0;
    step();
    chk("idle_indata", indata, 12'hFFF);
    chk("idle_hsync", hs_n, 1);
    chk("idle_vsync", vs_n, 1);
    chk("idle_ready", pif.pixel_ready, 0);
    repeat (19) step();
    enable = 1;
    run_until(4, 0, 9000);
    chk("period_mode2", last_period, 1728);

    seg = 3;
    restart(2'd1);
    run_until(4, 0, 9000);
    chk("period_mode1", last_period, 1716);

    seg = 4;
    restart(2'd3);
    run_until(4, 0, 9000);
    chk("period_mode3", last_period, 1716);

    // reset asserted in the middle of a visible line
    seg = 5;
    restart(2'd0);
    run_until(3, 300, 9000);
    reset_n = 0;
    #1;
    chk("midreset_indata", indata, 12'hFFF);
    chk("midreset_hsync", hs_n, 1);
    chk("midreset_vsync", vs_n, 1);
    chk("midreset_ready", pif.pixel_ready, 0);
    repeat (3) step();
    reset_n = 1;
    run_until(1, 0, 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
